// File: rtl/tx_channel_pkg.sv
// Shared types for the router transmit channel.
// Item width comes from the network defines so every router block agrees.
`ifndef NETWORK_DEFINES_SV
`include "network_defines.sv"
`endif

package tx_channel_pkg;

  localparam int ITEM_W = `HDR_SZ + `PL_SZ + `ADDR_SZ;

  typedef logic [ITEM_W-1:0] item_t;

endpackage

// File: rtl/network_defines.sv
// Shared network sizing macros used by every router-side block.
//   HDR_SZ     - header field width
//   PL_SZ      - payload field width
//   ADDR_SZ    - address field width
//   DIRECTIONS - number of router output directions
`ifndef NETWORK_DEFINES_SV
`define NETWORK_DEFINES_SV
`define HDR_SZ     2
`define PL_SZ      8
`define ADDR_SZ    4
`define DIRECTIONS 5
`endif

// File: rtl/tx_fifo.sv
// Circular item buffer for one transmit channel: storage array, pointers
// and occupancy count. DEPTH is a power of two so the pointers wrap
// naturally on overflow. Storage itself is never reset; only the
// bookkeeping is, which is enough to make the contents unreachable.
module tx_fifo
  import tx_channel_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic                     rd_en,
  input  item_t                    wr_data,
  output item_t                    rd_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  item_t           mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;

  // Storage write; no reset on the array.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_data;
  end

  // Pointer and occupancy bookkeeping; both pointers may move in one cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Head entry is always presented; the wrapper masks it when empty.
  assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/tx_channel.sv
// Router transmit channel: one instance per router output direction.
// Buffers items from the crossbar and presents the head item to the link
// with a valid/ack handshake. busy is fed back to the router's
// per-direction enable logic.
// Optional feature macro: TX_CNT_EN adds the tx_count port and a
// wrapping sent-item counter.
`ifndef NETWORK_DEFINES_SV
`include "network_defines.sv"
`endif

module tx_channel
  import tx_channel_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [`HDR_SZ+`PL_SZ+`ADDR_SZ-1:0] item_in,
  input  logic                            ena,
  output logic                            busy,
  output logic [`HDR_SZ+`PL_SZ+`ADDR_SZ-1:0] tx_item,
  output logic                            tx_valid,
`ifdef TX_CNT_EN
  output logic [CNT_W-1:0]                tx_count,
`endif
  input  logic                            tx_ack
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic          wr_en;
  logic          rd_en;
  item_t         head;
  logic [CW-1:0] count;

  // Full/empty flags straight from the occupancy count; a write is refused
  // while full even if the head leaves in the same cycle.
  always_comb begin
    busy     = (count == CW'(DEPTH));
    tx_valid = (count != '0);
    wr_en    = ena & ~busy;
    rd_en    = tx_valid & tx_ack;
    tx_item  = tx_valid ? head : '0;
  end

  tx_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_en),
    .rd_en   (rd_en),
    .wr_data (item_in),
    .rd_data (head),
    .count   (count)
  );

`ifdef TX_CNT_EN
  // Sent-item counter, wraps at 2^CNT_W.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)      tx_count <= '0;
    else if (rd_en) tx_count <= tx_count + 1'b1;
  end
`else
  // Counter omitted; CNT_W kept referenced so the parameter list is uniform.
  logic [CNT_W-1:0] unused_cnt_w;
  assign unused_cnt_w = '0;
`endif

endmodule

// File: doc/tx_channel.md
TX_CHANNEL -- requirements
Module: tx_channel

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning the number of buffer entries; legal values are 2, 4, 8 and 16.
REQ-002 SHALL have parameter CNT_W, default 16, meaning the width of the sent-item counter.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; every flop is rising-edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port item_in, input, `HDR_SZ+`PL_SZ+`ADDR_SZ bits: the item from the router crossbar.
REQ-006 SHALL have port ena, input, 1 bit: write strobe from the router for item_in.
REQ-007 SHALL have port busy, output, 1 bit: the channel cannot accept an item this cycle.
REQ-008 SHALL have port tx_item, output, same width as item_in: the head item driven onto the link.
REQ-009 SHALL have port tx_valid, output, 1 bit: tx_item holds a valid item.
REQ-010 SHALL have port tx_ack, input, 1 bit: the neighbour accepts tx_item this cycle.
REQ-011 SHALL have port tx_count, output, CNT_W bits: items sent so far; present only under TX_CNT_EN.

Function
REQ-012 SHALL store items in a circular FIFO of DEPTH entries, with write pointer, read pointer and occupancy count of $clog2(DEPTH)+1 bits.
REQ-013 SHALL drive busy combinationally as (count == DEPTH).
REQ-014 SHALL enqueue item_in on a rising edge when ena=1 and busy=0.
REQ-015 SHALL ignore ena while busy=1: no write, pointers unchanged, item discarded.
REQ-016 SHALL drive tx_valid = (count != 0), and tx_item = the head entry when tx_valid=1, else all zeros.
REQ-017 SHALL dequeue, advancing the read pointer, on a rising edge when tx_valid=1 and tx_ack=1.
REQ-018 SHALL ignore tx_ack while tx_valid=0.
REQ-019 SHALL wrap the pointers modulo DEPTH without skipping an entry.
REQ-020 SHALL, on a simultaneous enqueue and dequeue, update both pointers and leave count unchanged.
REQ-021 SHALL, when full, not enqueue even if a dequeue happens in the same cycle, because busy is already high.
REQ-022 SHALL, on an enqueue to an empty FIFO in cycle N, assert tx_valid in cycle N+1; latency is 1 cycle with no bypass path.
REQ-023 SHALL preserve the order of items; no reordering and no duplication.

Reset
REQ-024 SHALL on reset=1 immediately clear the pointers, count and tx_count, giving tx_valid=0, busy=0 and tx_item=0.
REQ-025 SHALL discard all buffered items on reset asserted mid-operation, including an item whose handshake is in progress.
REQ-026 SHALL not require buffer storage to be reset.
REQ-027 SHALL ignore ena and tx_ack while reset=1.

Configuration
REQ-028 SHALL, with TX_CNT_EN defined, provide tx_count, incrementing by 1 on each dequeue and wrapping from 2^CNT_W-1 to 0.
REQ-029 SHALL, with TX_CNT_EN undefined, omit the tx_count port and its counter; all other behaviour is identical.

Structure
REQ-030 SHALL take HDR_SZ, PL_SZ, ADDR_SZ and DIRECTIONS from the shared network defines file; no local redefinition.
REQ-031 SHALL implement the storage array and pointers in one sub-module, tx_fifo; tx_channel wraps it with busy/valid generation and the counter.
REQ-032 SHALL be instantiable once per router output direction, with ena and busy wired to the router's per-direction enable and busy.

Verification
REQ-033 SHALL cover: reset, then ena=1 with item_in=0x1A5 in cycle 0 and tx_ack=0 -> tx_valid=1 and tx_item=0x1A5 in cycle 1, busy=0.
REQ-034 SHALL cover: DEPTH=4, 4 writes with tx_ack=0 -> busy=1 after the 4th; a 5th ena is dropped; 4 acks then return items 1-4 in order and tx_valid=0.
REQ-035 SHALL cover: count=2, ena=1 and tx_ack=1 in the same cycle -> count stays 2; the head advances and the new item sits at the tail.
REQ-036 SHALL cover: full FIFO, ena=1 and tx_ack=1 together -> count becomes 3 and the ena item is dropped.
REQ-037 SHALL cover: 3 items buffered, reset pulsed mid-cycle -> tx_valid=0, busy=0 and tx_count=0 immediately, before any clock edge.
REQ-038 SHALL cover: TX_CNT_EN defined, CNT_W=4, 17 items sent -> tx_count=1, showing wrap; with the macro undefined, the port is absent and the design elaborates cleanly.
